// File: rtl/memory_arbiter_if.sv
// Cache-side and RAM-side signal bundle for the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches/RAM.
interface memory_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic              iwait;
  logic              dwait;
  logic [ADDR_W-1:0] iload;
  logic [ADDR_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic [1:0]        ramstate;
  logic [ADDR_W-1:0] ramload;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester RAM arbiter: dcache has priority, icache is forced a grant
// after STARVE_MAX consecutive dcache completions while it is waiting.
module memory_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input logic              CLK,
  input logic              RST,
  memory_arbiter_if.slave  bus
);

  localparam int unsigned ScntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [ScntW-1:0] ScntMax = ScntW'(STARVE_MAX);
  localparam logic [1:0] RamAccess = 2'd2;

  typedef enum logic [1:0] {StIdle, StDAcc, StIAcc} state_e;

  state_e           state_q, state_d;
  logic [ScntW-1:0] scnt_q, scnt_d;

  logic d_req, ram_done, d_done, i_done;

  assign d_req    = bus.dREN | bus.dWEN;
  assign ram_done = (bus.ramstate == RamAccess);
  // A completion only counts while the granted requester is still asking.
  assign d_done   = (state_q == StDAcc) && ram_done && d_req;
  assign i_done   = (state_q == StIAcc) && ram_done && bus.iREN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.iREN && (scnt_q == ScntMax)) state_d = StIAcc;
        else if (d_req)                      state_d = StDAcc;
        else if (bus.iREN)                   state_d = StIAcc;
      end
      StDAcc: if (!d_req || ram_done)    state_d = StIdle;
      StIAcc: if (!bus.iREN || ram_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Clear beats increment; increment saturates at the limit.
    scnt_d = scnt_q;
    if (!bus.iREN || i_done)               scnt_d = '0;
    else if (d_done && (scnt_q != ScntMax)) scnt_d = scnt_q + 1'b1;
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = {ADDR_W{1'b0}};
    bus.ramstore = {ADDR_W{1'b0}};
    bus.dwait    = 1'b1;
    bus.iwait    = 1'b1;
    unique case (state_q)
      StDAcc: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.dwait    = ~ram_done;
      end
      StIAcc: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = 1'b1;
        bus.iwait   = ~ram_done;
      end
      default: ;
    endcase
  end

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: per-cycle vector table plus starvation
// and reset-during-access sequences.
module tb_memory_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  memory_arbiter_if #(.ADDR_W(32)) bus ();

  memory_arbiter #(.STARVE_MAX(4), .ADDR_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ir, dr, dw;
    logic [1:0]  rs;
    logic [31:0] ia, da, ds, rl;
    logic        e_iw, e_dw, e_rr, e_rw;
    logic [31:0] e_ra, e_rst;
  } vec_t;

  vec_t vt[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic dw, input logic [1:0] rs,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                       input logic [31:0] rl);
    bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw; bus.ramstate = rs;
    bus.iaddr = ia; bus.daddr = da; bus.dstore = ds; bus.ramload = rl;
  endtask

  task automatic chk_outs(input string tag, input logic iw, input logic dw, input logic rr,
                          input logic rw, input logic [31:0] ra, input logic [31:0] rst_d);
    chk({tag, ".iwait"},    32'(bus.iwait),  32'(iw));
    chk({tag, ".dwait"},    32'(bus.dwait),  32'(dw));
    chk({tag, ".ramREN"},   32'(bus.ramREN), 32'(rr));
    chk({tag, ".ramWEN"},   32'(bus.ramWEN), 32'(rw));
    chk({tag, ".ramaddr"},  bus.ramaddr,     ra);
    chk({tag, ".ramstore"}, bus.ramstore,    rst_d);
  endtask

  initial begin
    //       ir dr dw rs    ia      da      ds      rl            iw dw rr rw ra      rstore
    // idle after reset
    vt[0]  = '{0, 0, 0, FREE, 0,     0,     0,     0,            1, 1, 0, 0, 0,     0};
    // lone icache read
    vt[1]  = '{1, 0, 0, FREE, 'h40,  0,     0,     0,            1, 1, 0, 0, 0,     0};
    vt[2]  = '{1, 0, 0, ACC,  'h40,  0,     0,     'hDEADBEEF,   0, 1, 1, 0, 'h40,  0};
    vt[3]  = '{0, 0, 0, FREE, 0,     0,     0,     0,            1, 1, 0, 0, 0,     0};
    // collision: dcache first, then icache
    vt[4]  = '{1, 1, 0, FREE, 'h80,  'h200, 'hAAAA, 0,           1, 1, 0, 0, 0,     0};
    vt[5]  = '{1, 1, 0, ACC,  'h80,  'h200, 'hAAAA, 'h11111111,  1, 0, 1, 0, 'h200, 'hAAAA};
    vt[6]  = '{1, 0, 0, FREE, 'h80,  0,     0,     0,            1, 1, 0, 0, 0,     0};
    vt[7]  = '{1, 0, 0, ACC,  'h80,  0,     0,     'h22222222,   0, 1, 1, 0, 'h80,  0};
    vt[8]  = '{0, 0, 0, FREE, 0,     0,     0,     0,            1, 1, 0, 0, 0,     0};
    // dirty write, ERROR retried
    vt[9]  = '{0, 1, 1, FREE, 0,     'h100, 'h1234, 0,           1, 1, 0, 0, 0,     0};
    vt[10] = '{0, 1, 1, BUSY, 0,     'h100, 'h1234, 0,           1, 1, 0, 1, 'h100, 'h1234};
    vt[11] = '{0, 1, 1, ERR,  0,     'h100, 'h1234, 0,           1, 1, 0, 1, 'h100, 'h1234};
    vt[12] = '{0, 1, 1, ACC,  0,     'h100, 'h1234, 'h5A5A5A5A,  1, 0, 0, 1, 'h100, 'h1234};
    vt[13] = '{0, 0, 0, FREE, 0,     0,     0,     0,            1, 1, 0, 0, 0,     0};
    // long access: BUSY x3 then ACCESS, no second completion
    vt[14] = '{1, 0, 0, FREE, 'h44,  0,     0,     0,            1, 1, 0, 0, 0,     0};
    vt[15] = '{1, 0, 0, BUSY, 'h44,  0,     0,     0,            1, 1, 1, 0, 'h44,  0};
    vt[16] = '{1, 0, 0, BUSY, 'h44,  0,     0,     0,            1, 1, 1, 0, 'h44,  0};
    vt[17] = '{1, 0, 0, BUSY, 'h44,  0,     0,     0,            1, 1, 1, 0, 'h44,  0};
    vt[18] = '{1, 0, 0, ACC,  'h44,  0,     0,     'hCAFEF00D,   0, 1, 1, 0, 'h44,  0};
    vt[19] = '{0, 0, 0, ACC,  0,     0,     0,     'hCAFEF00D,   1, 1, 0, 0, 0,     0};
    // granted dcache drops its request mid-grant
    vt[20] = '{0, 1, 0, FREE, 0,     'h300, 0,     0,            1, 1, 0, 0, 0,     0};
    vt[21] = '{0, 1, 0, BUSY, 0,     'h300, 0,     0,            1, 1, 1, 0, 'h300, 0};
    vt[22] = '{0, 0, 0, BUSY, 0,     'h300, 0,     0,            1, 1, 0, 0, 'h300, 0};
    vt[23] = '{0, 0, 0, ACC,  0,     'h300, 0,     0,            1, 1, 0, 0, 0,     0};

    RST = 1'b1;
    drive(0, 0, 0, FREE, 0, 0, 0, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 24; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vt[i].ir, vt[i].dr, vt[i].dw, vt[i].rs, vt[i].ia, vt[i].da, vt[i].ds, vt[i].rl);
      #1;
      chk_outs(tag, vt[i].e_iw, vt[i].e_dw, vt[i].e_rr, vt[i].e_rw, vt[i].e_ra, vt[i].e_rst);
      chk({tag, ".iload"}, bus.iload, vt[i].rl);
      chk({tag, ".dload"}, bus.dload, vt[i].rl);
      @(negedge CLK);
    end

    // Starvation: icache waits through 4 dcache completions, then wins.
    begin
      logic [31:0] exp_ra[12];
      logic [2:0]  exp_scnt[12];
      exp_ra   = '{0, 'h600, 0, 'h600, 0, 'h600, 0, 'h600, 0, 'h500, 0, 'h600};
      exp_scnt = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};
      for (int c = 0; c < 12; c++) begin
        drive(1, 1, 0, ACC, 'h500, 'h600, 0, 'h77);
        #1;
        chk($sformatf("starve%0d.ramaddr", c), bus.ramaddr, exp_ra[c]);
        chk($sformatf("starve%0d.iwait", c), 32'(bus.iwait), (exp_ra[c] == 'h500) ? 0 : 1);
        chk($sformatf("starve%0d.dwait", c), 32'(bus.dwait), (exp_ra[c] == 'h600) ? 0 : 1);
        chk($sformatf("starve%0d.scnt", c), 32'(dut.scnt_q), 32'(exp_scnt[c]));
        @(negedge CLK);
      end
    end

    // Reset while a dcache access is stalled on BUSY, with scnt nonzero.
    drive(0, 0, 0, FREE, 0, 0, 0, 0);
    @(negedge CLK);
    drive(1, 1, 0, ACC, 'h500, 'h700, 'h99, 0);
    repeat (2) @(negedge CLK);
    drive(1, 1, 0, FREE, 'h500, 'h700, 'h99, 0);
    @(negedge CLK);
    drive(1, 1, 0, BUSY, 'h500, 'h700, 'h99, 0);
    RST = 1'b1;
    #1;
    chk_outs("rst_pre", 1, 1, 1, 0, 'h700, 'h99);
    chk("rst_pre.scnt", 32'(dut.scnt_q), 1);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk_outs("rst_post", 1, 1, 0, 0, 0, 0);
    chk("rst_post.scnt", 32'(dut.scnt_q), 0);
    @(negedge CLK);
    #1;
    // From IDLE with dREN held the dcache is re-granted.
    chk_outs("rst_regrant", 1, 1, 1, 0, 'h700, 'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
